sequence_checker: RTL and testbench

//   Receive-side checker for the 5-word 3-bit cyclic code 000->011->010->101->111->000 (repeats).

---
 rtl/sequence_checker_if.sv | 17 +
 rtl/sequence_checker.sv | 164 ++++++++++++++++
 tb/tb_sequence_checker.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/sequence_checker_if.sv
// rtl/sequence_checker_if.sv - received word stream bundle for sequence_checker
//
// Purpose: carries the sampled 3-bit code word and its qualifier from the
//          link receiver into the checker.
// Signals:
//   In        3  received code word
//   In_valid  1  In is sampled on the clock edge only when high
// Modports:
//   master  drives In / In_valid (link side)
//   slave   samples In / In_valid (checker side)
interface sequence_checker_if;
   logic [2:0] In;
   logic       In_valid;

   modport master (output In, output In_valid);
   modport slave  (input  In, input  In_valid);
endinterface

// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - lock/flywheel checker for the 000-011-010-101-111 cyclic code
//
// Purpose: hunts for the 000 that starts a cycle, locks after LOCK_LEN
//          consecutive correct words, then flags each deviating word while
//          keeping a saturating error count and a per-cycle Frame pulse.
//          Lock is dropped after UNLOCK_MISS consecutive mismatches.
// Ports:
//   Clock     in   1      rising-edge clock
//   Reset     in   1      asynchronous, active-high reset
//   rx        slave      In (3) / In_valid (1) word stream
//   Clr_cnt   in   1      synchronous clear of ErrCount (wins over increment)
//   Locked    out  1      high while in LOCKED
//   Err       out  1      pulse: valid word mismatched while LOCKED
//   Frame     out  1      pulse: valid 111 matched while LOCKED
//   ErrCount  out  CNT_W  saturating count of Err pulses
//   Expected  out  3      word expected on the next valid sample
module sequence_checker #(
   parameter int LOCK_LEN    = 5,
   parameter int UNLOCK_MISS = 3,
   parameter int CNT_W       = 8
) (
   input  logic                 Clock,
   input  logic                 Reset,
   sequence_checker_if.slave    rx,
   input  logic                 Clr_cnt,
   output logic                 Locked,
   output logic                 Err,
   output logic                 Frame,
   output logic [CNT_W-1:0]     ErrCount,
   output logic [2:0]           Expected
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0]       LOCK_LEN_C    = 4'(LOCK_LEN);
   localparam logic [3:0]       UNLOCK_MISS_C = 4'(UNLOCK_MISS);
   localparam logic [CNT_W-1:0] CNT_MAX       = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [2:0]       expected_q, expected_d;
   logic [3:0]       run_q, run_d;
   logic [3:0]       miss_q, miss_d;
   logic             err_q, err_d;
   logic             frame_q, frame_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Successor in the code cycle; illegal words never reach this because
   // Expected only ever holds legal code words.
   function automatic logic [2:0] nxt(input logic [2:0] w);
      case (w)
         3'b000:  nxt = 3'b011;
         3'b011:  nxt = 3'b010;
         3'b010:  nxt = 3'b101;
         3'b101:  nxt = 3'b111;
         default: nxt = 3'b000;
      endcase
   endfunction

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q    <= HUNT;
         expected_q <= 3'b000;
         run_q      <= 4'd0;
         miss_q     <= 4'd0;
         err_q      <= 1'b0;
         frame_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         expected_q <= expected_d;
         run_q      <= run_d;
         miss_q     <= miss_d;
         err_q      <= err_d;
         frame_q    <= frame_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      expected_d = expected_q;
      run_d      = run_q;
      miss_d     = miss_q;
      err_d      = 1'b0;
      frame_d    = 1'b0;

      if (rx.In_valid) begin
         case (state_q)
            HUNT: begin
               if (rx.In == 3'b000) begin
                  expected_d = 3'b011;
                  run_d      = 4'd1;
                  miss_d     = 4'd0;
                  state_d    = (LOCK_LEN_C == 4'd1) ? LOCKED : SYNC;
               end
            end

            SYNC: begin
               if (rx.In == expected_q) begin
                  run_d      = run_q + 4'd1;
                  expected_d = nxt(rx.In);
                  if (run_q + 4'd1 == LOCK_LEN_C) begin
                     state_d = LOCKED;
                     miss_d  = 4'd0;
                  end
               end else if (rx.In == 3'b000) begin
                  // A stray 000 may be the true cycle start: restart the run on it.
                  run_d      = 4'd1;
                  expected_d = 3'b011;
               end else begin
                  state_d    = HUNT;
                  expected_d = 3'b000;
                  run_d      = 4'd0;
               end
            end

            LOCKED: begin
               // Flywheel: the expected word advances whether or not it matched.
               expected_d = nxt(expected_q);
               if (rx.In == expected_q) begin
                  miss_d  = 4'd0;
                  frame_d = (rx.In == 3'b111);
               end else begin
                  err_d  = 1'b1;
                  miss_d = miss_q + 4'd1;
                  if (miss_q + 4'd1 == UNLOCK_MISS_C) begin
                     state_d    = HUNT;
                     expected_d = 3'b000;
                     miss_d     = 4'd0;
                     run_d      = 4'd0;
                  end
               end
            end

            default: begin
               state_d    = HUNT;
               expected_d = 3'b000;
               run_d      = 4'd0;
               miss_d     = 4'd0;
            end
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (Clr_cnt) begin
         cnt_d = '0;
      end else if (err_d && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign Locked   = (state_q == LOCKED);
   assign Err      = err_q;
   assign Frame    = frame_q;
   assign ErrCount = cnt_q;
   assign Expected = expected_q;

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - directed self-checking bench for sequence_checker
module tb_sequence_checker;

   logic       Clock;
   logic       Reset;
   logic       Clr_cnt;
   logic       Locked;
   logic       Err;
   logic       Frame;
   logic [7:0] ErrCount;
   logic [2:0] Expected;

   int errors = 0;
   int checks = 0;

   logic [2:0] seq [5];
   int         idx;

   sequence_checker_if bus ();

   sequence_checker #(
      .LOCK_LEN    (5),
      .UNLOCK_MISS (3),
      .CNT_W       (8)
   ) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .rx       (bus.slave),
      .Clr_cnt  (Clr_cnt),
      .Locked   (Locked),
      .Err      (Err),
      .Frame    (Frame),
      .ErrCount (ErrCount),
      .Expected (Expected)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive on the falling edge, sample 1 time unit after the rising edge.
   task automatic step(input logic [2:0] w, input logic v, input logic clr);
      @(negedge Clock);
      bus.In       = w;
      bus.In_valid = v;
      Clr_cnt      = clr;
      @(posedge Clock);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic lk, input logic er, input logic fr,
                          input logic [7:0] cnt, input logic [2:0] ex);
      chk({tag, ".Locked"},   {7'd0, Locked}, {7'd0, lk});
      chk({tag, ".Err"},      {7'd0, Err},    {7'd0, er});
      chk({tag, ".Frame"},    {7'd0, Frame},  {7'd0, fr});
      chk({tag, ".ErrCount"}, ErrCount,       cnt);
      chk({tag, ".Expected"}, {5'd0, Expected}, {5'd0, ex});
   endtask

   initial begin
      seq[0] = 3'b000; seq[1] = 3'b011; seq[2] = 3'b010; seq[3] = 3'b101; seq[4] = 3'b111;
      bus.In       = 3'b000;
      bus.In_valid = 1'b0;
      Clr_cnt      = 1'b0;
      Reset        = 1'b1;
      #12;
      chk_out("reset", 1'b0, 1'b0, 1'b0, 8'd0, 3'b000);
      @(negedge Clock);
      Reset = 1'b0;

      // Acquire lock: 000 011 010 101 111
      step(3'b000, 1'b1, 1'b0); chk_out("acq0", 1'b0, 1'b0, 1'b0, 8'd0, 3'b011);
      step(3'b011, 1'b1, 1'b0); chk_out("acq1", 1'b0, 1'b0, 1'b0, 8'd0, 3'b010);
      step(3'b010, 1'b1, 1'b0); chk_out("acq2", 1'b0, 1'b0, 1'b0, 8'd0, 3'b101);
      step(3'b101, 1'b1, 1'b0); chk_out("acq3", 1'b0, 1'b0, 1'b0, 8'd0, 3'b111);
      step(3'b111, 1'b1, 1'b0); chk_out("acq4", 1'b1, 1'b0, 1'b0, 8'd0, 3'b000);

      // In_valid low holds everything
      step(3'b110, 1'b0, 1'b0); chk_out("idle", 1'b1, 1'b0, 1'b0, 8'd0, 3'b000);

      // One clean locked cycle; Frame only on the 111
      step(3'b000, 1'b1, 1'b0); chk_out("cyc0", 1'b1, 1'b0, 1'b0, 8'd0, 3'b011);
      step(3'b011, 1'b1, 1'b0); chk_out("cyc1", 1'b1, 1'b0, 1'b0, 8'd0, 3'b010);
      step(3'b010, 1'b1, 1'b0); chk_out("cyc2", 1'b1, 1'b0, 1'b0, 8'd0, 3'b101);
      step(3'b101, 1'b1, 1'b0); chk_out("cyc3", 1'b1, 1'b0, 1'b0, 8'd0, 3'b111);
      step(3'b111, 1'b1, 1'b0); chk_out("cyc4", 1'b1, 1'b0, 1'b1, 8'd0, 3'b000);

      // Single bad word, flywheel continues, miss resets on 101
      step(3'b000, 1'b1, 1'b0); chk_out("bad0", 1'b1, 1'b0, 1'b0, 8'd0, 3'b011);
      step(3'b011, 1'b1, 1'b0); chk_out("bad1", 1'b1, 1'b0, 1'b0, 8'd0, 3'b010);
      step(3'b110, 1'b1, 1'b0); chk_out("bad2", 1'b1, 1'b1, 1'b0, 8'd1, 3'b101);
      step(3'b101, 1'b1, 1'b0); chk_out("bad3", 1'b1, 1'b0, 1'b0, 8'd1, 3'b111);

      // Clear with no valid word: state untouched
      step(3'b000, 1'b0, 1'b1); chk_out("clr", 1'b1, 1'b0, 1'b0, 8'd0, 3'b111);

      // Three consecutive bad words drop lock (miss was reset by the 101)
      step(3'b001, 1'b1, 1'b0); chk_out("unl0", 1'b1, 1'b1, 1'b0, 8'd1, 3'b000);
      step(3'b001, 1'b1, 1'b0); chk_out("unl1", 1'b1, 1'b1, 1'b0, 8'd2, 3'b011);
      step(3'b001, 1'b1, 1'b0); chk_out("unl2", 1'b0, 1'b1, 1'b0, 8'd3, 3'b000);

      // HUNT ignores non-000 words without flagging
      step(3'b011, 1'b1, 1'b0); chk_out("hunt", 1'b0, 1'b0, 1'b0, 8'd3, 3'b000);

      // SYNC restart on stray 000, then lock
      step(3'b000, 1'b1, 1'b0); chk_out("rs0", 1'b0, 1'b0, 1'b0, 8'd3, 3'b011);
      step(3'b011, 1'b1, 1'b0); chk_out("rs1", 1'b0, 1'b0, 1'b0, 8'd3, 3'b010);
      step(3'b000, 1'b1, 1'b0); chk_out("rs2", 1'b0, 1'b0, 1'b0, 8'd3, 3'b011);
      step(3'b011, 1'b1, 1'b0); chk_out("rs3", 1'b0, 1'b0, 1'b0, 8'd3, 3'b010);
      step(3'b010, 1'b1, 1'b0); chk_out("rs4", 1'b0, 1'b0, 1'b0, 8'd3, 3'b101);
      step(3'b101, 1'b1, 1'b0); chk_out("rs5", 1'b0, 1'b0, 1'b0, 8'd3, 3'b111);
      step(3'b111, 1'b1, 1'b0); chk_out("rs6", 1'b1, 1'b0, 1'b0, 8'd3, 3'b000);

      // SYNC mismatch on a non-000 word returns to HUNT
      // (skipped here to stay locked for the saturation run)

      // Drive the counter to saturation with bad/good pairs that never unlock
      idx = 0;
      for (int i = 0; i < 260; i++) begin
         step(3'b001, 1'b1, 1'b0);
         idx = (idx + 1) % 5;
         step(seq[idx], 1'b1, 1'b0);
         idx = (idx + 1) % 5;
      end
      chk("sat.ErrCount", ErrCount, 8'd255);
      chk("sat.Locked", {7'd0, Locked}, 8'd1);
      chk("sat.Expected", {5'd0, Expected}, {5'd0, seq[idx]});

      // One more error stays at 255
      step(3'b001, 1'b1, 1'b0);
      idx = (idx + 1) % 5;
      chk("sat2.ErrCount", ErrCount, 8'd255);
      chk("sat2.Err", {7'd0, Err}, 8'd1);
      step(seq[idx], 1'b1, 1'b0);
      idx = (idx + 1) % 5;
      chk("sat3.Err", {7'd0, Err}, 8'd0);

      // Clear beats a simultaneous increment
      step(3'b100, 1'b1, 1'b1);
      idx = (idx + 1) % 5;
      chk("clrinc.ErrCount", ErrCount, 8'd0);
      chk("clrinc.Err", {7'd0, Err}, 8'd1);
      chk("clrinc.Locked", {7'd0, Locked}, 8'd1);
      chk("clrinc.Expected", {5'd0, Expected}, {5'd0, seq[idx]});

      // Error after clear counts from zero
      step(3'b110, 1'b1, 1'b0);
      chk("post.ErrCount", ErrCount, 8'd1);

      // Async reset mid-cycle clears outputs without a clock edge
      @(negedge Clock);
      bus.In_valid = 1'b0;
      #2;
      Reset = 1'b1;
      #1;
      chk_out("areset", 1'b0, 1'b0, 1'b0, 8'd0, 3'b000);
      @(negedge Clock);
      Reset = 1'b0;

      // SYNC mismatch on non-000 word goes back to HUNT
      step(3'b000, 1'b1, 1'b0); chk_out("sh0", 1'b0, 1'b0, 1'b0, 8'd0, 3'b011);
      step(3'b101, 1'b1, 1'b0); chk_out("sh1", 1'b0, 1'b0, 1'b0, 8'd0, 3'b000);
      step(3'b011, 1'b1, 1'b0); chk_out("sh2", 1'b0, 1'b0, 1'b0, 8'd0, 3'b000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
